// File: rtl/flash_xip_pkg.sv
// Shared types and constants for the flash XIP read cache.
package flash_xip_pkg;

  // Request sequencer states
  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StFwdSetup,
    StFwdAccess,
    StResp
  } state_e;

  // Default memory-mapped flash window (256 MB)
  localparam logic [31:0] FLASH_BASE_DEF = 32'h3000_0000;
  localparam logic [31:0] FLASH_END_DEF  = 32'h3fff_ffff;

  // SPI controller register window, always passed straight through
  localparam logic [31:0] SPI_REG_BASE = 32'h1000_1000;
  localparam logic [31:0] SPI_REG_END  = 32'h1000_1fff;

  // Inclusive address range test
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] lo,
                                         input logic [31:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/flash_xip_cache_array.sv
// Direct-mapped tag/data/valid store: combinational read, synchronous write,
// global invalidate that overrides a same-cycle fill.
module flash_xip_cache_array
  import flash_xip_pkg::*;
#(
  parameter int unsigned LINES = 16
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [$clog2(LINES)-1:0]        i_ridx,
  output logic                            o_rvalid,
  output logic [26-$clog2(LINES)-1:0]     o_rtag,
  output logic [31:0]                     o_rdata,
  input  logic                            i_we,
  input  logic [$clog2(LINES)-1:0]        i_widx,
  input  logic [26-$clog2(LINES)-1:0]     i_wtag,
  input  logic [31:0]                     i_wdata,
  input  logic                            i_inv
);

  localparam int unsigned TAG_W = 26 - $clog2(LINES);

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES];

  // Valid bits: invalidate wins over a coincident fill
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else if (i_inv) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_widx] <= 1'b1;
    end
  end

  // Tag and data payload; contents are meaningless until the valid bit is set
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_tag[i_widx]  <= i_wtag;
      r_data[i_widx] <= i_wdata;
    end
  end

  assign o_rvalid = r_valid[i_ridx];
  assign o_rtag   = r_tag[i_ridx];
  assign o_rdata  = r_data[i_ridx];

endmodule

// File: rtl/flash_xip_cache.sv
// Word-granular direct-mapped read cache in front of the SPI/XIP APB slave.
// Flash reads are cached, flash writes are rejected, everything else passes
// through. Optional hit/miss counters are built when FLASH_CACHE_STATS_EN is
// defined.
module flash_xip_cache
  import flash_xip_pkg::*;
#(
  parameter int unsigned LINES      = 16,
  parameter logic [31:0] FLASH_BASE = FLASH_BASE_DEF,
  parameter logic [31:0] FLASH_END  = FLASH_END_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  input  logic [2:0]  in_pprot,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  output logic [31:0] out_paddr,
  output logic        out_psel,
  output logic        out_penable,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  output logic [2:0]  out_pprot,
  input  logic        out_pready,
  input  logic [31:0] out_prdata,
  input  logic        out_pslverr,
`ifdef FLASH_CACHE_STATS_EN
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses,
`endif
  input  logic        inv
);

  localparam int unsigned IDX   = $clog2(LINES);
  localparam int unsigned TAG_W = 26 - IDX;

  state_e      r_state;
  logic [31:0] r_paddr;
  logic        r_pwrite;
  logic [31:0] r_pwdata;
  logic [3:0]  r_pstrb;
  logic [2:0]  r_pprot;

  logic        r_in_pready;
  logic [31:0] r_in_prdata;
  logic        r_in_pslverr;
  logic [31:0] r_out_paddr;
  logic        r_out_psel;
  logic        r_out_penable;
  logic        r_out_pwrite;
  logic [31:0] r_out_pwdata;
  logic [3:0]  r_out_pstrb;
  logic [2:0]  r_out_pprot;

  logic [IDX-1:0]   w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_flash;
  logic             w_rvalid;
  logic [TAG_W-1:0] w_rtag;
  logic [31:0]      w_rdata;
  logic             w_hit;
  logic             w_fill;

  // Only bits [27:0] are tagged; the flash window is exactly 256 MB
  assign w_idx   = r_paddr[IDX+1:2];
  assign w_tag   = r_paddr[27:IDX+2];
  assign w_flash = addr_in_range(r_paddr, FLASH_BASE, FLASH_END);
  assign w_hit   = w_flash && !r_pwrite && w_rvalid && (w_rtag == w_tag);
  // Fill only on a clean downstream completion of a flash read
  assign w_fill  = (r_state == StFwdAccess) && out_pready && w_flash && !r_pwrite &&
                   !out_pslverr;

  flash_xip_cache_array #(
    .LINES (LINES)
  ) u_array (
    .i_clk    (clock),
    .i_rst_n  (reset),
    .i_ridx   (w_idx),
    .o_rvalid (w_rvalid),
    .o_rtag   (w_rtag),
    .o_rdata  (w_rdata),
    .i_we     (w_fill),
    .i_widx   (w_idx),
    .i_wtag   (w_tag),
    .i_wdata  (out_prdata),
    .i_inv    (inv)
  );

  // Request sequencer with registered upstream and downstream outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= StIdle;
      r_paddr       <= '0;
      r_pwrite      <= 1'b0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
      r_pprot       <= '0;
      r_in_pready   <= 1'b0;
      r_in_prdata   <= '0;
      r_in_pslverr  <= 1'b0;
      r_out_paddr   <= '0;
      r_out_psel    <= 1'b0;
      r_out_penable <= 1'b0;
      r_out_pwrite  <= 1'b0;
      r_out_pwdata  <= '0;
      r_out_pstrb   <= '0;
      r_out_pprot   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_in_pready <= 1'b0;
          if (in_psel && !in_penable) begin
            r_paddr  <= in_paddr;
            r_pwrite <= in_pwrite;
            r_pwdata <= in_pwdata;
            r_pstrb  <= in_pstrb;
            r_pprot  <= in_pprot;
            r_state  <= StLookup;
          end
        end
        StLookup: begin
          if (w_flash && r_pwrite) begin
            r_in_prdata  <= '0;
            r_in_pslverr <= 1'b1;
            r_in_pready  <= 1'b1;
            r_state      <= StResp;
          end else if (w_hit) begin
            r_in_prdata  <= w_rdata;
            r_in_pslverr <= 1'b0;
            r_in_pready  <= 1'b1;
            r_state      <= StResp;
          end else begin
            r_out_paddr   <= r_paddr;
            r_out_pwrite  <= r_pwrite;
            r_out_pwdata  <= r_pwdata;
            r_out_pstrb   <= r_pstrb;
            r_out_pprot   <= r_pprot;
            r_out_psel    <= 1'b1;
            r_out_penable <= 1'b0;
            r_state       <= StFwdSetup;
          end
        end
        StFwdSetup: begin
          r_out_penable <= 1'b1;
          r_state       <= StFwdAccess;
        end
        StFwdAccess: begin
          if (out_pready) begin
            r_in_prdata   <= out_prdata;
            r_in_pslverr  <= out_pslverr;
            r_in_pready   <= 1'b1;
            r_out_psel    <= 1'b0;
            r_out_penable <= 1'b0;
            r_state       <= StResp;
          end
        end
        StResp: begin
          r_in_pready <= 1'b0;
          r_state     <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef FLASH_CACHE_STATS_EN
  logic [31:0] r_stat_hits;
  logic [31:0] r_stat_misses;

  // Saturating flash-read hit/miss counters, cleared only by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stat_hits   <= '0;
      r_stat_misses <= '0;
    end else if (r_state == StLookup && w_flash && !r_pwrite) begin
      if (w_hit) begin
        if (r_stat_hits != 32'hffff_ffff) r_stat_hits <= r_stat_hits + 32'd1;
      end else begin
        if (r_stat_misses != 32'hffff_ffff) r_stat_misses <= r_stat_misses + 32'd1;
      end
    end
  end

  assign stat_hits   = r_stat_hits;
  assign stat_misses = r_stat_misses;
`endif

  assign in_pready   = r_in_pready;
  assign in_prdata   = r_in_prdata;
  assign in_pslverr  = r_in_pslverr;
  assign out_paddr   = r_out_paddr;
  assign out_psel    = r_out_psel;
  assign out_penable = r_out_penable;
  assign out_pwrite  = r_out_pwrite;
  assign out_pwdata  = r_out_pwdata;
  assign out_pstrb   = r_out_pstrb;
  assign out_pprot   = r_out_pprot;

endmodule

// File: tb/tb_flash_xip_cache.sv
// Directed bench for flash_xip_cache with a delay-programmable downstream slave.
module tb_flash_xip_cache;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] in_paddr;
  logic        in_psel, in_penable, in_pwrite;
  logic [31:0] in_pwdata;
  logic [3:0]  in_pstrb;
  logic [2:0]  in_pprot;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        in_pslverr;
  logic [31:0] out_paddr;
  logic        out_psel, out_penable, out_pwrite;
  logic [31:0] out_pwdata;
  logic [3:0]  out_pstrb;
  logic [2:0]  out_pprot;
  logic        out_pready;
  logic [31:0] out_prdata;
  logic        out_pslverr;
  logic        inv;
`ifdef FLASH_CACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  flash_xip_cache dut (
    .clock       (clock),
    .reset       (reset),
    .in_paddr    (in_paddr),
    .in_psel     (in_psel),
    .in_penable  (in_penable),
    .in_pwrite   (in_pwrite),
    .in_pwdata   (in_pwdata),
    .in_pstrb    (in_pstrb),
    .in_pprot    (in_pprot),
    .in_pready   (in_pready),
    .in_prdata   (in_prdata),
    .in_pslverr  (in_pslverr),
    .out_paddr   (out_paddr),
    .out_psel    (out_psel),
    .out_penable (out_penable),
    .out_pwrite  (out_pwrite),
    .out_pwdata  (out_pwdata),
    .out_pstrb   (out_pstrb),
    .out_pprot   (out_pprot),
    .out_pready  (out_pready),
    .out_prdata  (out_prdata),
    .out_pslverr (out_pslverr),
`ifdef FLASH_CACHE_STATS_EN
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses),
`endif
    .inv         (inv)
  );

  always #5 clock = ~clock;

  int          n_total = 0;
  int          n_bad = 0;
  int          ds_delay = 2;
  logic [31:0] ds_data = '0;
  logic        ds_err = 1'b0;
  int          ds_cnt;
  int          ds_txn = 0;
  logic [31:0] ds_last_addr, ds_last_wdata;
  logic        ds_last_write;
  logic [3:0]  ds_last_strb;

  // Downstream slave: answers after ds_delay access cycles, counts setups
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_pready  <= 1'b0;
      out_prdata  <= '0;
      out_pslverr <= 1'b0;
      ds_cnt      <= 0;
    end else begin
      out_pready <= 1'b0;
      if (out_psel && !out_penable) begin
        ds_txn        <= ds_txn + 1;
        ds_last_addr  <= out_paddr;
        ds_last_write <= out_pwrite;
        ds_last_wdata <= out_pwdata;
        ds_last_strb  <= out_pstrb;
      end
      if (out_psel && out_penable && !out_pready) begin
        if (ds_cnt >= ds_delay) begin
          out_pready  <= 1'b1;
          out_prdata  <= ds_data;
          out_pslverr <= ds_err;
          ds_cnt      <= 0;
        end else begin
          ds_cnt <= ds_cnt + 1;
        end
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One upstream APB transfer; lat counts cycles from setup (T0) to in_pready.
  // inv is pulsed in cycle T(inv_at) when inv_at > 0.
  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                          input int inv_at, output logic [31:0] rd, output logic err,
                          output int lat);
    @(posedge clock); #1;
    in_paddr = addr; in_pwrite = wr; in_pwdata = wd; in_psel = 1'b1; in_penable = 1'b0;
    @(posedge clock); #1;
    in_penable = 1'b1;
    lat = 1;
    inv = (inv_at == 1);
    while (!in_pready && lat < 3000) begin
      @(posedge clock); #1;
      lat++;
      inv = (lat == inv_at);
    end
    inv = 1'b0;
    check_val("pready_seen", {31'b0, in_pready}, 32'd1);
    rd  = in_prdata;
    err = in_pslverr;
    @(posedge clock); #1;
    in_psel = 1'b0; in_penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat, t0, n;

  initial begin
    reset = 1'b1; inv = 1'b0;
    in_paddr = '0; in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0;
    in_pwdata = '0; in_pstrb = 4'hf; in_pprot = 3'd0;
    #3 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_pready", {31'b0, in_pready}, 32'd0);
    check_val("rst_prdata", in_prdata, 32'd0);
    check_val("rst_pslverr", {31'b0, in_pslverr}, 32'd0);
    check_val("rst_out_psel", {31'b0, out_psel}, 32'd0);
    check_val("rst_out_penable", {31'b0, out_penable}, 32'd0);
    check_val("rst_out_paddr", out_paddr, 32'd0);
    reset = 1'b1;

    // Cold miss with a 200-cycle downstream wait
    ds_delay = 200; ds_data = 32'hdead_beef; t0 = ds_txn;
    apb_xfer(32'h3000_0100, 1'b0, 32'd0, 0, rd, err, lat);
    check_val("cold_data", rd, 32'hdead_beef);
    check_val("cold_err", {31'b0, err}, 32'd0);
    check_val("cold_lat", lat, 32'd205);
    check_val("cold_txn", ds_txn - t0, 32'd1);

    // Repeat read hits in two cycles
    ds_delay = 2; ds_data = 32'h1111_1111; t0 = ds_txn;
    apb_xfer(32'h3000_0100, 1'b0, 32'd0, 0, rd, err, lat);
    check_val("hit_data", rd, 32'hdead_beef);
    check_val("hit_lat", lat, 32'd2);
    check_val("hit_txn", ds_txn - t0, 32'd0);

    // Standalone invalidate pulse forces a refetch
    @(posedge clock); #1; inv = 1'b1;
    @(posedge clock); #1; inv = 1'b0;
    t0 = ds_txn;
    apb_xfer(32'h3000_0100, 1'b0, 32'd0, 0, rd, err, lat);
    check_val("inv_miss_data", rd, 32'h1111_1111);
    check_val("inv_miss_txn", ds_txn - t0, 32'd1);
    check_val("inv_miss_lat", lat, 32'd7);
    apb_xfer(32'h3000_0100, 1'b0, 32'd0, 0, rd, err, lat);
    check_val("inv_rehit_data", rd, 32'h1111_1111);

    // Conflict on index 0
    ds_data = 32'haaaa_0040;
    apb_xfer(32'h3000_0040, 1'b0, 32'd0, 0, rd, err, lat);
    check_val("conf_a", rd, 32'haaaa_0040);
    ds_data = 32'hbbbb_0000; t0 = ds_txn;
    apb_xfer(32'h3000_0000, 1'b0, 32'd0, 0, rd, err, lat);
    check_val("conf_b", rd, 32'hbbbb_0000);
    check_val("conf_b_txn", ds_txn - t0, 32'd1);
    ds_data = 32'hcccc_0040; t0 = ds_txn;
    apb_xfer(32'h3000_0040, 1'b0, 32'd0, 0, rd, err, lat);
    check_val("conf_a_again", rd, 32'hcccc_0040);
    check_val("conf_a_again_txn", ds_txn - t0, 32'd1);

    // SPI register write passes through
    ds_data = 32'h0; t0 = ds_txn;
    apb_xfer(32'h1000_1018, 1'b1, 32'h0000_0001, 0, rd, err, lat);
    check_val("pt_txn", ds_txn - t0, 32'd1);
    check_val("pt_addr", ds_last_addr, 32'h1000_1018);
    check_val("pt_write", {31'b0, ds_last_write}, 32'd1);
    check_val("pt_wdata", ds_last_wdata, 32'h0000_0001);
    check_val("pt_strb", {28'b0, ds_last_strb}, 32'hf);
    check_val("pt_err", {31'b0, err}, 32'd0);
    // Register reads never fill
    ds_data = 32'h0000_0055; t0 = ds_txn;
    apb_xfer(32'h1000_1018, 1'b0, 32'd0, 0, rd, err, lat);
    apb_xfer(32'h1000_1018, 1'b0, 32'd0, 0, rd, err, lat);
    check_val("pt_rd_data", rd, 32'h0000_0055);
    check_val("pt_rd_txn", ds_txn - t0, 32'd2);

    // Flash write rejected locally
    t0 = ds_txn;
    apb_xfer(32'h3000_0000, 1'b1, 32'h1234_5678, 0, rd, err, lat);
    check_val("fw_err", {31'b0, err}, 32'd1);
    check_val("fw_data", rd, 32'd0);
    check_val("fw_lat", lat, 32'd2);
    check_val("fw_txn", ds_txn - t0, 32'd0);

    // Invalidate in the fill cycle (delay 4 -> out_pready in T8)
    ds_delay = 4; ds_data = 32'h7777_7777;
    apb_xfer(32'h3000_0200, 1'b0, 32'd0, 8, rd, err, lat);
    check_val("invfill_data", rd, 32'h7777_7777);
    check_val("invfill_lat", lat, 32'd9);
    ds_delay = 2; ds_data = 32'h8888_8888; t0 = ds_txn;
    apb_xfer(32'h3000_0200, 1'b0, 32'd0, 0, rd, err, lat);
    check_val("invfill_remiss", ds_txn - t0, 32'd1);
    check_val("invfill_remiss_data", rd, 32'h8888_8888);

    // Invalidate during a hit leaves that response intact
    ds_data = 32'h9999_9999; t0 = ds_txn;
    apb_xfer(32'h3000_0200, 1'b0, 32'd0, 1, rd, err, lat);
    check_val("invhit_data", rd, 32'h8888_8888);
    check_val("invhit_lat", lat, 32'd2);
    check_val("invhit_txn", ds_txn - t0, 32'd0);
    apb_xfer(32'h3000_0200, 1'b0, 32'd0, 0, rd, err, lat);
    check_val("invhit_next", rd, 32'h9999_9999);
    check_val("invhit_next_txn", ds_txn - t0, 32'd1);

    // Window boundaries
    ds_data = 32'h3ffc_0001;
    apb_xfer(32'h3fff_fffc, 1'b0, 32'd0, 0, rd, err, lat);
    ds_data = 32'h0; t0 = ds_txn;
    apb_xfer(32'h3fff_fffc, 1'b0, 32'd0, 0, rd, err, lat);
    check_val("end_hit_data", rd, 32'h3ffc_0001);
    check_val("end_hit_txn", ds_txn - t0, 32'd0);
    ds_data = 32'h4000_0000; t0 = ds_txn;
    apb_xfer(32'h4000_0000, 1'b0, 32'd0, 0, rd, err, lat);
    apb_xfer(32'h4000_0000, 1'b0, 32'd0, 0, rd, err, lat);
    check_val("past_end_txn", ds_txn - t0, 32'd2);

    // Downstream error: forwarded, no fill
    ds_err = 1'b1; ds_data = 32'hbad0_0bad;
    apb_xfer(32'h3000_0300, 1'b0, 32'd0, 0, rd, err, lat);
    check_val("dserr_err", {31'b0, err}, 32'd1);
    ds_err = 1'b0; ds_data = 32'h0300_0300; t0 = ds_txn;
    apb_xfer(32'h3000_0300, 1'b0, 32'd0, 0, rd, err, lat);
    check_val("dserr_remiss", ds_txn - t0, 32'd1);
    check_val("dserr_remiss_err", {31'b0, err}, 32'd0);
    check_val("dserr_remiss_data", rd, 32'h0300_0300);

`ifdef FLASH_CACHE_STATS_EN
    check_val("stat_hits", stat_hits, 32'd4);
    check_val("stat_misses", stat_misses, 32'd11);
`endif

    // Reset in the middle of a downstream access
    ds_delay = 1000;
    @(posedge clock); #1;
    in_paddr = 32'h3000_0500; in_pwrite = 1'b0; in_psel = 1'b1; in_penable = 1'b0;
    @(posedge clock); #1;
    in_penable = 1'b1;
    n = 0;
    while (!(out_psel && out_penable) && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check_val("mid_access", {31'b0, out_penable}, 32'd1);
    reset = 1'b0;
    #1;
    check_val("arst_psel", {31'b0, out_psel}, 32'd0);
    check_val("arst_penable", {31'b0, out_penable}, 32'd0);
    in_psel = 1'b0; in_penable = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1; ds_delay = 2; ds_data = 32'h5a5a_5a5a; t0 = ds_txn;
    apb_xfer(32'h3fff_fffc, 1'b0, 32'd0, 0, rd, err, lat);
    check_val("post_rst_miss", ds_txn - t0, 32'd1);
    check_val("post_rst_data", rd, 32'h5a5a_5a5a);
    check_val("post_rst_lat", lat, 32'd7);
    apb_xfer(32'h3fff_fffc, 1'b0, 32'd0, 0, rd, err, lat);
    check_val("post_rst_hit", rd, 32'h5a5a_5a5a);
`ifdef FLASH_CACHE_STATS_EN
    check_val("post_rst_hits", stat_hits, 32'd1);
    check_val("post_rst_misses", stat_misses, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/flash_xip_cache.md
Name: flash_xip_cache

Overview:
- Direct-mapped, word-granular read cache between the CPU-side APB interconnect and the SPI/XIP APB slave.
- Flash-window reads that hit return in 2 cycles; misses run one full XIP SPI transaction downstream (hundreds of cycles).
- Non-flash accesses (SPI register window etc.) pass through unmodified.
- Flash writes are rejected with pslverr; no downstream traffic.

Parameters:
- LINES, 16, number of one-word lines; power of two, >=2; IDX=log2(LINES)
- FLASH_BASE, 32'h30000000, first flash byte address
- FLASH_END, 32'h3fffffff, last flash byte address

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- in_paddr/in_psel/in_penable/in_pwrite  in  32/1/1/1  upstream APB request
- in_pwdata/in_pstrb/in_pprot  in  32/4/3  upstream write data, strobes, prot
- in_pready/in_prdata/in_pslverr  out  1/32/1  upstream response
- out_paddr/out_psel/out_penable/out_pwrite  out  32/1/1/1  downstream APB request
- out_pwdata/out_pstrb/out_pprot  out  32/4/3  downstream write data, strobes, prot
- out_pready/out_prdata/out_pslverr  in  1/32/1  downstream response
- inv  in  1  one-cycle pulse; invalidates all lines

Behaviour:
- Reset values: all valid bits 0; state IDLE; in_pready=0, in_prdata=0, in_pslverr=0; out_psel=0, out_penable=0, out_paddr=0, out_pwrite=0, out_pwdata=0, out_pstrb=0, out_pprot=0.
- Reset is asynchronous: asserting it mid-transaction drops out_psel/out_penable immediately and discards the in-flight request.
- Address split (word-aligned; in_paddr[1:0] ignored):
  - index = paddr[IDX+1:2]
  - tag = paddr[27:IDX+2]
  - Only [27:0] are tagged; the window is 256 MB.
- Flash hit: FLASH_BASE <= paddr <= FLASH_END.
- All outputs are registered. in_pready is a single-cycle pulse, asserted only in RESP.
- States and transitions:
  - IDLE: when in_psel && !in_penable, latch paddr, pwrite, pwdata, pstrb, pprot; go to LOOKUP.
  - LOOKUP:
    - flash && pwrite: RESP with pslverr=1, prdata=0.
    - flash && read && valid[index] && tag match: RESP with prdata=data[index], pslverr=0.
    - otherwise: FWD_SETUP.
  - FWD_SETUP: drive latched fields downstream; out_psel=1, out_penable=0; go to FWD_ACCESS.
  - FWD_ACCESS: out_psel=1, out_penable=1; hold until out_pready.
    - Capture out_prdata/out_pslverr, then deassert psel/penable.
    - Flash read with pslverr=0: fill data[index], tag[index], and set valid[index].
    - Go to RESP.
  - RESP: in_pready=1 for one cycle with the captured prdata/pslverr; go to IDLE.
- Latency, counted from the upstream setup cycle T0:
  - Hit or rejected write: in_pready at T2.
  - Miss or bypass: in_pready one cycle after the downstream out_pready cycle.
- Upstream protocol:
  - Upstream holds psel/penable high until in_pready.
  - A new setup phase is recognised only in IDLE.
- inv:
  - Clears all valid bits the cycle after the pulse.
  - inv coincident with a fill: invalidate wins; the line stays invalid but the fetched data is still returned upstream.
  - inv during a hit response does not alter that response.
- Downstream error on a flash read: no fill; pslverr forwarded.
- Address boundaries:
  - FLASH_END exactly is cached.
  - FLASH_END+1 is treated as non-flash and bypassed.
  - Tag aliasing across the 28-bit window is impossible by construction.

Optional Feature:
- Macro FLASH_CACHE_STATS_EN.
- Defined:
  - Adds outputs stat_hits and stat_misses, 32 bits each.
  - stat_hits increments on each flash-read hit in LOOKUP.
  - stat_misses increments on each flash-read miss.
  - Both saturate at 32'hffffffff; cleared by reset only, not by inv.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package flash_xip_pkg:
  - state enum: IDLE, LOOKUP, FWD_SETUP, FWD_ACCESS, RESP
  - FLASH_BASE/FLASH_END defaults
  - SPI register window constants, 32'h10001000–32'h10001fff
- One sub-module, flash_xip_cache_array: tag/data/valid storage with a combinational read port, a synchronous write port and a global invalidate.

Test Plan:
- Cold read 0x30000100, downstream returns 0xDEADBEEF after 200 cycles -> one downstream transaction; in_prdata=0xDEADBEEF, pslverr=0.
- Repeat read 0x30000100 -> no out_psel activity; in_pready at T2 with 0xDEADBEEF.
- Conflict (LINES=16): read 0x30000040 (index 0), then 0x30000000 (index 0, different tag) -> second access misses and refills; re-read of 0x30000040 misses again.
- Pass-through: write 0x10001018 data 0x1 -> out_paddr=0x10001018, out_pwrite=1, out_pwdata=0x1; no fill. Separately, write 0x30000000 -> pslverr=1, no downstream activity.
- Invalidate:
  - inv pulse after the hit on 0x30000100 -> next read of 0x30000100 misses.
  - inv in the same cycle as the fill -> data is still returned, and the following read misses.
- Reset and errors:
  - reset asserted during FWD_ACCESS -> out_psel=0 immediately; after release the cache is empty.
  - Downstream pslverr=1 on a miss -> forwarded upstream; a re-read misses.
  - With FLASH_CACHE_STATS_EN, after the above sequence the counters equal the exact hit/miss counts.
